// File: rtl/can_tx_serializer.sv
// CAN 2.0A transmit serializer: SOF..IFS with on-the-fly CRC-15 and bit stuffing; frames are accepted only in IDLE, SOF is driven the cycle after acceptance.
// Bus errors are checked at the mid-bit sample point; on an error the node releases to recessive for one bit time and then returns to IDLE.
module can_tx_serializer #(
  parameter int          CLKS_PER_BIT = 8,
  parameter logic [14:0] CRC_POLY     = 15'h4599
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic [10:0] tx_id,
  input  logic        tx_rtr,
  input  logic [3:0]  tx_dlc,
  input  logic [63:0] tx_data,
  input  logic        bus_bit,
  output logic        tx_bit,
  output logic        busy,
  output logic        tx_done,
  output logic        arb_lost,
  output logic        bit_error,
  output logic        ack_error
);

  localparam int PW = $clog2(CLKS_PER_BIT);
  localparam logic [PW-1:0] PH_LAST   = PW'(CLKS_PER_BIT - 1);
  localparam logic [PW-1:0] PH_SAMPLE = PW'(CLKS_PER_BIT / 2);

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_SOF    = 4'd1;
  localparam logic [3:0] ST_ARB    = 4'd2;
  localparam logic [3:0] ST_CTRL   = 4'd3;
  localparam logic [3:0] ST_DATA   = 4'd4;
  localparam logic [3:0] ST_CRC    = 4'd5;
  localparam logic [3:0] ST_CRCDEL = 4'd6;
  localparam logic [3:0] ST_ACK    = 4'd7;
  localparam logic [3:0] ST_ACKDEL = 4'd8;
  localparam logic [3:0] ST_EOF    = 4'd9;
  localparam logic [3:0] ST_IFS    = 4'd10;
  localparam logic [3:0] ST_ABORT  = 4'd11;

  logic [3:0]    state_q, state_d;
  logic [6:0]    cnt_q, cnt_d;
  logic [PW-1:0] phase_q, phase_d;
  logic          tx_q, tx_d;
  logic          stuff_q, stuff_d;
  logic [2:0]    run_q, run_d;
  logic [14:0]   crc_q, crc_d;
  logic [17:0]   hdr_q, hdr_d;
  logic [63:0]   data_q, data_d;
  logic [6:0]    nbits_q, nbits_d;

  logic          sample, err_any, stuff_now, in_crc_span;
  logic [14:0]   crc_sh;
  logic [17:0]   hdr_sh;
  logic [63:0]   data_sh;
  logic [3:0]    adv_state;
  logic [6:0]    adv_cnt;
  logic          adv_bit;

  assign tx_ready = (state_q == ST_IDLE);
  assign busy     = !tx_ready;
  assign tx_bit   = tx_q;

  assign sample    = !rst && (state_q != ST_IDLE) && (state_q != ST_ABORT) && (phase_q == PH_SAMPLE);
  assign arb_lost  = sample && (state_q == ST_ARB) && tx_q && !bus_bit;
  assign ack_error = sample && (state_q == ST_ACK) && bus_bit;
  assign bit_error = sample && (((state_q == ST_ARB) && !tx_q && bus_bit) ||
                                ((state_q != ST_ARB) && (state_q != ST_ACK) && (bus_bit != tx_q)));
  assign err_any   = arb_lost || ack_error || bit_error;
  assign tx_done   = !rst && (state_q == ST_IFS) && (cnt_q == 7'd2) && (phase_q == PH_LAST);

  assign in_crc_span = (state_q == ST_SOF) || (state_q == ST_ARB) ||
                       (state_q == ST_CTRL) || (state_q == ST_DATA);
  assign stuff_now   = (in_crc_span || (state_q == ST_CRC)) && (run_q == 3'd5);

  // Field shifters move only when a real (unstuffed) bit ends, so a stuff bit leaves them untouched.
  always_comb begin
    crc_sh = crc_q;
    if (!stuff_q && in_crc_span)
      crc_sh = {crc_q[13:0], 1'b0} ^ ((tx_q ^ crc_q[14]) ? CRC_POLY : 15'h0);
    else if (!stuff_q && (state_q == ST_CRC))
      crc_sh = {crc_q[13:0], 1'b0};
    hdr_sh  = (!stuff_q && ((state_q == ST_ARB) || (state_q == ST_CTRL))) ? {hdr_q[16:0], 1'b0} : hdr_q;
    data_sh = (!stuff_q && (state_q == ST_DATA)) ? {data_q[62:0], 1'b0} : data_q;
  end

  always_comb begin
    adv_state = state_q;
    adv_cnt   = cnt_q + 7'd1;
    adv_bit   = 1'b1;
    case (state_q)
      ST_SOF: begin
        adv_state = ST_ARB;
        adv_cnt   = 7'd0;
        adv_bit   = hdr_sh[17];
      end
      ST_ARB: begin
        adv_bit = hdr_sh[17];
        if (cnt_q == 7'd11) begin
          adv_state = ST_CTRL;
          adv_cnt   = 7'd0;
        end
      end
      ST_CTRL: begin
        adv_bit = hdr_sh[17];
        if (cnt_q == 7'd5) begin
          adv_cnt = 7'd0;
          if (nbits_q == 7'd0) begin
            adv_state = ST_CRC;
            adv_bit   = crc_sh[14];
          end else begin
            adv_state = ST_DATA;
            adv_bit   = data_sh[63];
          end
        end
      end
      ST_DATA: begin
        adv_bit = data_sh[63];
        if (cnt_q == nbits_q - 7'd1) begin
          adv_state = ST_CRC;
          adv_cnt   = 7'd0;
          adv_bit   = crc_sh[14];
        end
      end
      ST_CRC: begin
        adv_bit = crc_sh[14];
        if (cnt_q == 7'd14) begin
          adv_state = ST_CRCDEL;
          adv_cnt   = 7'd0;
          adv_bit   = 1'b1;
        end
      end
      ST_CRCDEL: begin
        adv_state = ST_ACK;
        adv_cnt   = 7'd0;
      end
      ST_ACK: begin
        adv_state = ST_ACKDEL;
        adv_cnt   = 7'd0;
      end
      ST_ACKDEL: begin
        adv_state = ST_EOF;
        adv_cnt   = 7'd0;
      end
      ST_EOF: begin
        if (cnt_q == 7'd6) begin
          adv_state = ST_IFS;
          adv_cnt   = 7'd0;
        end
      end
      ST_IFS: begin
        if (cnt_q == 7'd2) begin
          adv_state = ST_IDLE;
          adv_cnt   = 7'd0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    tx_d    = tx_q;
    stuff_d = stuff_q;
    run_d   = run_q;
    crc_d   = crc_q;
    hdr_d   = hdr_q;
    data_d  = data_q;
    nbits_d = nbits_q;
    if (state_q == ST_IDLE) begin
      if (tx_valid) begin
        state_d = ST_SOF;
        cnt_d   = 7'd0;
        phase_d = '0;
        tx_d    = 1'b0;
        stuff_d = 1'b0;
        run_d   = 3'd1;
        crc_d   = 15'h0;
        hdr_d   = {tx_id, tx_rtr, 2'b00, tx_dlc};
        data_d  = tx_data;
        nbits_d = tx_rtr ? 7'd0 : ((tx_dlc > 4'd8) ? 7'd64 : {tx_dlc, 3'b000});
      end
    end else begin
      phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PW'(1);
      if (err_any) begin
        state_d = ST_ABORT;
        cnt_d   = 7'd0;
      end else if (phase_q == PH_LAST) begin
        if (state_q == ST_ABORT) begin
          // One full recessive bit time after the failing bit, then release.
          tx_d = 1'b1;
          if (cnt_q == 7'd0) cnt_d = 7'd1;
          else               state_d = ST_IDLE;
        end else begin
          crc_d  = crc_sh;
          hdr_d  = hdr_sh;
          data_d = data_sh;
          if (stuff_now) begin
            tx_d    = ~tx_q;
            stuff_d = 1'b1;
            run_d   = 3'd1;
          end else begin
            state_d = adv_state;
            cnt_d   = adv_cnt;
            tx_d    = adv_bit;
            stuff_d = 1'b0;
            run_d   = (adv_bit != tx_q) ? 3'd1 : ((run_q == 3'd7) ? 3'd7 : run_q + 3'd1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 7'd0;
      phase_q <= '0;
      tx_q    <= 1'b1;
      stuff_q <= 1'b0;
      run_q   <= 3'd0;
      crc_q   <= 15'h0;
      hdr_q   <= 18'h0;
      data_q  <= 64'h0;
      nbits_q <= 7'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      tx_q    <= tx_d;
      stuff_q <= stuff_d;
      run_q   <= run_d;
      crc_q   <= crc_d;
      hdr_q   <= hdr_d;
      data_q  <= data_d;
      nbits_q <= nbits_d;
    end
  end

endmodule

// File: tb/tb_can_tx_serializer.sv
// Directed bench for can_tx_serializer: loopback bus with per-bit-period forcing, reference stuffed bitstream model.
module tb_can_tx_serializer;
  localparam int          CPB  = 8;
  localparam logic [14:0] POLY = 15'h4599;
  localparam int          LIMIT = 2000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tx_valid = 1'b0;
  logic [10:0] tx_id = 11'h0;
  logic        tx_rtr = 1'b0;
  logic [3:0]  tx_dlc = 4'h0;
  logic [63:0] tx_data = 64'h0;
  logic        bus_bit;
  logic        tx_ready, tx_bit, busy, tx_done, arb_lost, bit_error, ack_error;

  int   cur_per = -1;
  int   force_per = -1;
  logic force_val = 1'b0;
  assign bus_bit = (force_per >= 0 && cur_per == force_per) ? force_val : tx_bit;

  can_tx_serializer #(.CLKS_PER_BIT(CPB), .CRC_POLY(POLY)) dut (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_id(tx_id),
    .tx_rtr(tx_rtr), .tx_dlc(tx_dlc), .tx_data(tx_data), .bus_bit(bus_bit), .tx_bit(tx_bit),
    .busy(busy), .tx_done(tx_done), .arb_lost(arb_lost), .bit_error(bit_error), .ack_error(ack_error)
  );

  always #5 clk = ~clk;

  logic u[0:127];
  int   un;
  logic ex[0:255];
  int   en, ack_per, fdp;
  logic obs[0:255];
  int   n_done, n_arb, n_bit, n_ack;
  int   rel_done, rel_arb, rel_bit, rel_ack, end_rel;
  logic tx1, busy1;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic chk_stream(input string tag, input int upto);
    for (int i = 0; i < upto; i++)
      check($sformatf("%s bit%0d", tag, i), 32'(obs[i]), 32'(ex[i]));
  endtask

  // Expected on-wire bit sequence: unstuffed SOF..CRC, stuffed, then the fixed recessive tail.
  task automatic build_model(input logic [10:0] id, input logic rtr, input logic [3:0] dlc, input logic [63:0] data);
    int nb, ds, run;
    logic [14:0] crc;
    logic nx, last;
    un = 0;
    u[un] = 1'b0; un++;
    for (int i = 10; i >= 0; i--) begin u[un] = id[i]; un++; end
    u[un] = rtr; un++;
    u[un] = 1'b0; un++;
    u[un] = 1'b0; un++;
    for (int i = 3; i >= 0; i--) begin u[un] = dlc[i]; un++; end
    nb = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
    ds = un;
    for (int i = 0; i < nb * 8; i++) begin u[un] = data[63 - i]; un++; end
    crc = 15'h0;
    for (int i = 0; i < un; i++) begin
      nx  = u[i] ^ crc[14];
      crc = {crc[13:0], 1'b0} ^ (nx ? POLY : 15'h0);
    end
    for (int i = 14; i >= 0; i--) begin u[un] = crc[i]; un++; end
    en = 0; run = 0; last = 1'b0; fdp = -1;
    for (int i = 0; i < un; i++) begin
      if (nb > 0 && i == ds) fdp = en;
      ex[en] = u[i]; en++;
      if (run > 0 && u[i] == last) run++;
      else run = 1;
      last = u[i];
      if (run == 5) begin
        ex[en] = ~last; en++;
        last = ~last;
        run = 1;
      end
    end
    ex[en] = 1'b1; en++;
    ack_per = en;
    for (int i = 0; i < 12; i++) begin ex[en] = 1'b1; en++; end
  endtask

  task automatic run_frame(input logic [10:0] id, input logic rtr, input logic [3:0] dlc, input logic [63:0] data,
                           input int fper, input logic fval, input int rst_at);
    int t, w;
    bit fin;
    for (int i = 0; i < 256; i++) obs[i] = 1'bx;
    n_done = 0; n_arb = 0; n_bit = 0; n_ack = 0;
    rel_done = -1; rel_arb = -1; rel_bit = -1; rel_ack = -1; end_rel = -1;
    tx1 = 1'bx; busy1 = 1'bx;
    force_per = fper; force_val = fval; cur_per = -1;
    @(posedge clk); #1;
    tx_id = id; tx_rtr = rtr; tx_dlc = dlc; tx_data = data; tx_valid = 1'b1;
    w = 0;
    while (tx_ready !== 1'b1 && w < 50) begin @(posedge clk); #1; w++; end
    @(posedge clk); #1;
    tx_valid = 1'b0;
    t = 0; fin = 0;
    while (!fin && t < LIMIT) begin
      cur_per = t / CPB;
      if (rst_at >= 0 && t == rst_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        fin = 1;
      end else begin
        @(negedge clk);
        if (t == 0) begin tx1 = tx_bit; busy1 = busy; end
        if (t % CPB == CPB / 2) obs[t / CPB] = tx_bit;
        if (tx_done === 1'b1)   begin n_done++; if (rel_done < 0) rel_done = t + 1; end
        if (arb_lost === 1'b1)  begin n_arb++;  if (rel_arb < 0)  rel_arb  = t + 1; end
        if (bit_error === 1'b1) begin n_bit++;  if (rel_bit < 0)  rel_bit  = t + 1; end
        if (ack_error === 1'b1) begin n_ack++;  if (rel_ack < 0)  rel_ack  = t + 1; end
        if (tx_ready === 1'b1) begin
          end_rel = t + 1;
          fin = 1;
        end else begin
          @(posedge clk); #1;
          t++;
        end
      end
    end
    cur_per = -1;
    force_per = -1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset tx_bit", 32'(tx_bit), 32'd1);
    check("reset tx_ready", 32'(tx_ready), 32'd1);
    check("reset busy", 32'(busy), 32'd0);
    check("reset pulses", 32'({tx_done, arb_lost, bit_error, ack_error}), 32'd0);

    // Nominal frame with ACK supplied by the bus.
    build_model(11'h123, 1'b0, 4'd1, {8'hA5, 56'h0});
    run_frame(11'h123, 1'b0, 4'd1, {8'hA5, 56'h0}, ack_per, 1'b0, -1);
    chk_stream("f123", en);
    check("f123 done_at", rel_done, 8 * en);
    check("f123 done_count", n_done, 1);
    check("f123 ready_at", end_rel, 8 * en + 1);
    check("f123 err_count", n_arb + n_bit + n_ack, 0);

    // All-dominant start: stuff bit in period 5.
    build_model(11'h000, 1'b0, 4'd0, 64'h0);
    run_frame(11'h000, 1'b0, 4'd0, 64'h0, ack_per, 1'b0, -1);
    check("id0 period5_stuff", 32'(obs[5]), 32'd1);
    check("id0 period6_id6", 32'(obs[6]), 32'd0);
    chk_stream("id0", en);
    check("id0 done_count", n_done, 1);

    // Arbitration loss on the fourth ID bit.
    run_frame(11'h7FF, 1'b0, 4'd0, 64'h0, 4, 1'b0, -1);
    check("arb count", n_arb, 1);
    check("arb at", rel_arb, 37);
    check("arb next_bit", 32'(obs[5]), 32'd1);
    check("arb ready_at", end_rel, 49);
    check("arb other", n_done + n_bit + n_ack, 0);

    // Nobody acknowledges.
    build_model(11'h555, 1'b0, 4'd2, {16'h0F3C, 48'h0});
    run_frame(11'h555, 1'b0, 4'd2, {16'h0F3C, 48'h0}, -1, 1'b0, -1);
    chk_stream("noack", ack_per + 1);
    check("noack count", n_ack, 1);
    check("noack at", rel_ack, 8 * ack_per + 5);
    check("noack ready_at", end_rel, 8 * (ack_per + 2) + 1);
    check("noack other", n_done + n_bit + n_arb, 0);

    // Bus pulled recessive during the first (dominant) data bit.
    build_model(11'h123, 1'b0, 4'd1, {8'h5A, 56'h0});
    run_frame(11'h123, 1'b0, 4'd1, {8'h5A, 56'h0}, fdp, 1'b1, -1);
    check("biterr count", n_bit, 1);
    check("biterr at", rel_bit, 8 * fdp + 5);
    check("biterr held_bit", 32'(obs[fdp]), 32'd0);
    check("biterr next_bit", 32'(obs[fdp + 1]), 32'd1);
    check("biterr ready_at", end_rel, 8 * (fdp + 2) + 1);
    check("biterr other", n_done + n_arb + n_ack, 0);

    // Reset in the data field, then a fresh frame.
    build_model(11'h2AB, 1'b0, 4'd2, {16'hC396, 48'h0});
    run_frame(11'h2AB, 1'b0, 4'd2, {16'hC396, 48'h0}, ack_per, 1'b0, 8 * (fdp + 4) + 2);
    @(negedge clk);
    check("midrst tx_bit", 32'(tx_bit), 32'd1);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst tx_ready", 32'(tx_ready), 32'd1);
    check("midrst pulses", 32'({tx_done, arb_lost, bit_error, ack_error}), 32'd0);
    build_model(11'h0F0, 1'b0, 4'd1, {8'h33, 56'h0});
    run_frame(11'h0F0, 1'b0, 4'd1, {8'h33, 56'h0}, ack_per, 1'b0, -1);
    check("postrst sof", 32'(tx1), 32'd0);
    check("postrst busy", 32'(busy1), 32'd1);
    chk_stream("postrst", en);
    check("postrst done_count", n_done, 1);

    // DLC above 8 clamps to 8 bytes.
    build_model(11'h1AB, 1'b0, 4'hF, 64'h0123456789ABCDEF);
    run_frame(11'h1AB, 1'b0, 4'hF, 64'h0123456789ABCDEF, ack_per, 1'b0, -1);
    chk_stream("dlcF", en);
    check("dlcF done_at", rel_done, 8 * en);

    // Remote frame: no data regardless of DLC.
    build_model(11'h1AB, 1'b1, 4'hF, 64'h0123456789ABCDEF);
    run_frame(11'h1AB, 1'b1, 4'hF, 64'h0123456789ABCDEF, ack_per, 1'b0, -1);
    chk_stream("rtr", en);
    check("rtr done_at", rel_done, 8 * en);
    check("rtr ready_at", end_rel, 8 * en + 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/can_tx_serializer.md
Name: can_tx_serializer

Overview:
- Transmit-side frame serializer for one CAN node, upstream of the wired-AND can_bus interface.
- Accepts a standard-format frame (11-bit ID) over a valid/ready handshake.
- Serializes the frame bit-by-bit, computing CRC-15 on the fly and inserting stuff bits. Its tx_bit drives this node's bit of can_bus input_data.
- Monitors the resolved bus line for arbitration loss, bit errors and missing ACK, and reports them to the node's error-handling logic.

Parameters:
- CLKS_PER_BIT, 8, clock cycles per CAN bit time; must be ≥4 and even.
- CRC_POLY, 15'h4599, CAN CRC-15 generator polynomial.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- tx_valid  input  1  upstream frame request.
- tx_ready  output  1  high only in IDLE; frame is accepted on tx_valid&tx_ready.
- tx_id  input  11  identifier, sent MSB first.
- tx_rtr  input  1  remote frame flag; 1 = no data field.
- tx_dlc  input  4  data length code, sent as given.
- tx_data  input  64  payload; byte 0 = tx_data[63:56], sent MSB first.
- bus_bit  input  1  resolved can_bus data line; 0 = dominant.
- tx_bit  output  1  bit driven toward the bus; 1 = recessive.
- busy  output  1  high from acceptance through the end of IFS.
- tx_done  output  1  one-cycle pulse when a frame completes successfully.
- arb_lost  output  1  one-cycle pulse on arbitration loss.
- bit_error  output  1  one-cycle pulse on a bit mismatch outside arbitration and the ACK slot.
- ack_error  output  1  one-cycle pulse when the ACK slot is sampled recessive.

Behaviour:
- Reset values:
  - tx_bit=1, tx_ready=1, busy=0.
  - All pulse outputs 0.
  - State IDLE; bit counter, CRC register and stuff counter all cleared.
  - Reset mid-frame returns to IDLE on the next edge with tx_bit=1.
- Handshake:
  - On acceptance, all inputs are registered.
  - DLC>8 is treated as 8 data bytes. RTR=1 gives 0 data bytes regardless of DLC.
  - SOF is driven starting the cycle after acceptance.
- Bit timing:
  - A phase counter runs 0..CLKS_PER_BIT-1.
  - tx_bit changes only when phase==0.
  - bus_bit is sampled at phase==CLKS_PER_BIT/2; all error and arbitration decisions are taken at the sample point.
- States and field order:
  - IDLE
  - SOF(0)
  - ARB: ID[10:0], then RTR
  - CTRL: IDE=0, r0=0, DLC[3:0]
  - DATA: 8×bytes bits; skipped when bytes=0
  - CRC: 15 bits, MSB first
  - CRC_DEL(1)
  - ACK(1, recessive)
  - ACK_DEL(1)
  - EOF: 7 recessive
  - IFS: 3 recessive
  - back to IDLE
- CRC:
  - Covers SOF through the last data bit, unstuffed bits only.
  - Update per bit: nxt = bit ^ crc[14]; crc = {crc[13:0],1'b0} ^ (nxt ? CRC_POLY : 0).
  - Initial value 0.
- Bit stuffing:
  - Applies from SOF through the last CRC bit.
  - After 5 consecutive equal transmitted bits (stuff bits included), insert one complementary bit.
  - A stuff bit starts a new run of length 1.
  - Stuff bits do not enter the CRC and do not advance the field counter.
  - A stuff bit pending after the last CRC bit is still sent before CRC_DEL.
  - No stuffing from CRC_DEL onward.
- Arbitration (ID bits and RTR only, including stuff bits in that span):
  - If tx_bit=1 and bus_bit=0 at the sample point, pulse arb_lost.
  - tx_bit=1 from the next phase==0; go to IDLE at the end of that bit time; tx_ready=1.
  - The frame is dropped; upstream resubmits.
- Bit error:
  - Applies in SOF, CTRL, DATA, CRC, the delimiters, EOF and IFS.
  - Trigger: sampled bus_bit differs from tx_bit.
  - Also applies in ARB when tx_bit=0 and bus_bit=1.
  - Action: pulse bit_error, abort as for arbitration loss.
- ACK:
  - bus_bit sampled 1 → pulse ack_error, abort.
  - bus_bit sampled 0 → continue.
- tx_done:
  - Pulses on the last clock of the final IFS bit; tx_ready rises the following cycle.
  - At most one of tx_done/arb_lost/bit_error/ack_error fires per frame.
- Frame length:
  - Unstuffed frame length = 47 + 8×bytes bits.
  - Back-to-back requests are accepted only in IDLE, so there is no overlap.

Test Plan:
- ID=11'h123, RTR=0, DLC=1, data 0xA5, bus=tx_bit with ACK slot forced 0:
  - CRC field equals the reference-model CRC-15 of the unstuffed SOF..data bits.
  - tx_done pulses exactly (frame bits)×CLKS_PER_BIT cycles after acceptance.
- ID=0, DLC=0, RTR=0:
  - SOF plus ID[10:7] gives five 0s, so bit period 5 is a stuff bit =1.
  - ID[6] follows in period 6; each later run of five equal bits is followed by its complement.
- ID=11'h7FF, bus forced 0 during ID bit 3 (period 4):
  - arb_lost pulses once at that sample point.
  - tx_bit=1 from the next bit; tx_ready=1 after that bit time; no tx_done.
- ACK slot left recessive (bus=tx_bit throughout):
  - ack_error pulses at the ACK sample point; EOF is not sent; tx_ready returns to 1.
- Bus forced 1 during a dominant data bit:
  - bit_error pulses at that sample point; abort follows as specified.
- rst asserted during DATA:
  - Next cycle: tx_bit=1, busy=0, tx_ready=1, no pulses.
  - A new request is then accepted and its SOF starts the following cycle.
- DLC=4'hF, RTR=0:
  - The DLC field transmits 1111 and exactly 64 data bits are sent.
  - With RTR=1, 0 data bits are sent.
